psg_access_sched: RTL and testbench

- Schedules all host-side accesses to the sound chips (YM2203 #0, YM2203 #1, SAA1099) on the internal data bus.
- Requests enter a small in-order FIFO. The block generates chip strobes with per-chip setup and pulse timing.
- After each YM2203 write, it enforces that chip's busy/recovery time before issuing the next access to the same chip.
- Sits between the host bus front end (filtered, clk-synchronous requests) and the chip pins; replaces direct strobe forming with queued, paced accesses.

---
 rtl/psg_access_sched.sv | 260 ++++++++++++++++++++++++++
 tb/tb_psg_access_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psg_access_sched.sv
// Queued, paced access scheduler for two YM2203s and one SAA1099 on the internal bus.
// Strobe timing is set by phase counters; YM recovery timers block the queue head until they expire.

module psg_fifo #(
  parameter int W  = 12,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat,
  output logic         o_empty,
  output logic         o_full
);
  logic [W-1:0] r_mem [2**AW];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dat     = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
  end
endmodule

module psg_access_sched #(
  parameter int FIFO_AW     = 2,
  parameter int YM_PULSE    = 14,
  parameter int SAA_SETUP   = 3,
  parameter int SAA_PULSE   = 6,
  parameter int YM_ADDR_GAP = 40,
  parameter int YM_DATA_GAP = 1200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rd,
  input  logic [1:0] req_tgt,
  input  logic       req_a0,
  input  logic [7:0] req_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       yma0,
  output logic       ymcs0_n,
  output logic       ymcs1_n,
  output logic       ymrd_n,
  output logic       ymwr_n,
  output logic       saaa0,
  output logic       saacs_n,
  output logic       saawr_n,
  output logic       busy
);
  localparam int CW = 8;
  localparam logic [11:0] ADDR_GAP = 12'(YM_ADDR_GAP);
  localparam logic [11:0] DATA_GAP = 12'(YM_DATA_GAP);

  typedef struct packed {
    logic       rd;
    logic [1:0] tgt;
    logic       a0;
    logic [7:0] data;
  } req_t;

  typedef struct packed {
    logic       yma0;
    logic       ymcs0_n;
    logic       ymcs1_n;
    logic       ymrd_n;
    logic       ymwr_n;
    logic       saaa0;
    logic       saacs_n;
    logic       saawr_n;
    logic       d_oe;
    logic [7:0] d_out;
  } pins_t;

  localparam pins_t PINS_IDLE = '{yma0: 1'b0, ymcs0_n: 1'b1, ymcs1_n: 1'b1, ymrd_n: 1'b1,
                                  ymwr_n: 1'b1, saaa0: 1'b0, saacs_n: 1'b1, saawr_n: 1'b1,
                                  d_oe: 1'b0, d_out: 8'h00};

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW-1:0]   w_len;
  req_t            r_cur;
  req_t            w_cur_nxt;
  req_t            w_req;
  req_t            w_head;
  logic [11:0]     r_rec0;
  logic [11:0]     r_rec1;
  pins_t           r_pins;
  pins_t           w_pins;
  logic            r_rd_valid;
  logic [7:0]      r_rd_data;
  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_head_ok;
  logic            w_cur_saa;
  logic            w_nxt_saa;
  logic            w_ym_wr_done;

  assign w_req  = {req_rd, req_tgt, req_a0, req_data};
  // Reserved target is swallowed here so it never occupies a slot
  assign w_push = req_valid && !w_full && (req_tgt != 2'd3);

  psg_fifo #(.W($bits(req_t)), .AW(FIFO_AW)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_dat  (w_req),
    .o_dat  (w_head),
    .o_empty(w_empty),
    .o_full (w_full)
  );

  always_comb begin
    case (w_head.tgt)
      2'd0:    w_head_ok = (r_rec0 == '0);
      2'd1:    w_head_ok = (r_rec1 == '0);
      default: w_head_ok = 1'b1;
    endcase
  end

  assign w_pop     = (r_state == S_IDLE) && !w_empty && w_head_ok;
  assign w_cur_nxt = w_pop ? w_head : r_cur;
  assign w_cur_saa = (r_cur.tgt == 2'd2);
  assign w_nxt_saa = (w_cur_nxt.tgt == 2'd2);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_len       = '0;
    case (r_state)
      S_SETUP: w_len = w_cur_saa ? CW'(SAA_SETUP - 1) : '0;
      S_PULSE: w_len = w_cur_saa ? CW'(SAA_PULSE - 1) : CW'(YM_PULSE - 1);
      default: w_len = '0;
    endcase
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = '0;
        end
      end
      S_SETUP: begin
        if (r_cnt == w_len) begin
          w_state_nxt = S_PULSE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_PULSE: begin
        if (r_cnt == w_len) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Pins are decoded from the next state so the registered outputs line up with r_state
  always_comb begin
    w_pins = PINS_IDLE;
    if (w_state_nxt != S_IDLE) begin
      if (w_nxt_saa) w_pins.saaa0 = w_cur_nxt.a0;
      else           w_pins.yma0  = w_cur_nxt.a0;
      if (!w_cur_nxt.rd) begin
        w_pins.d_oe  = 1'b1;
        w_pins.d_out = w_cur_nxt.data;
      end
    end
    if (w_nxt_saa && !w_cur_nxt.rd) begin
      if (w_state_nxt == S_SETUP || w_state_nxt == S_PULSE) w_pins.saacs_n = 1'b0;
      if (w_state_nxt == S_PULSE) w_pins.saawr_n = 1'b0;
    end
    if (!w_nxt_saa && w_state_nxt == S_PULSE) begin
      w_pins.ymcs0_n = (w_cur_nxt.tgt != 2'd0);
      w_pins.ymcs1_n = (w_cur_nxt.tgt != 2'd1);
      w_pins.ymrd_n  = !w_cur_nxt.rd;
      w_pins.ymwr_n  = w_cur_nxt.rd;
    end
  end

  assign w_ym_wr_done = (r_state == S_HOLD) && !r_cur.rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cur      <= '0;
      r_pins     <= PINS_IDLE;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 8'h00;
      r_rec0     <= '0;
      r_rec1     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cur      <= w_cur_nxt;
      r_pins     <= w_pins;
      r_rd_valid <= (w_state_nxt == S_HOLD) && w_cur_nxt.rd;
      if (r_state == S_PULSE && w_state_nxt == S_HOLD && r_cur.rd)
        r_rd_data <= w_cur_saa ? 8'hFF : d_in;
      if (w_ym_wr_done && r_cur.tgt == 2'd0) r_rec0 <= r_cur.a0 ? DATA_GAP : ADDR_GAP;
      else if (r_rec0 != '0)                  r_rec0 <= r_rec0 - 1'b1;
      if (w_ym_wr_done && r_cur.tgt == 2'd1) r_rec1 <= r_cur.a0 ? DATA_GAP : ADDR_GAP;
      else if (r_rec1 != '0)                  r_rec1 <= r_rec1 - 1'b1;
    end
  end

  assign req_ready = !w_full;
  assign busy      = !w_empty || (r_state != S_IDLE);
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign d_out     = r_pins.d_out;
  assign d_oe      = r_pins.d_oe;
  assign yma0      = r_pins.yma0;
  assign ymcs0_n   = r_pins.ymcs0_n;
  assign ymcs1_n   = r_pins.ymcs1_n;
  assign ymrd_n    = r_pins.ymrd_n;
  assign ymwr_n    = r_pins.ymwr_n;
  assign saaa0     = r_pins.saaa0;
  assign saacs_n   = r_pins.saacs_n;
  assign saawr_n   = r_pins.saawr_n;
endmodule

// File: tb/tb_psg_access_sched.sv
// Scoreboard bench: accepted requests queue expected accesses; a pin monitor decodes each access and compares.
module tb_psg_access_sched;
  localparam int YM_PULSE  = 14;
  localparam int SAA_SETUP = 3;
  localparam int SAA_PULSE = 6;
  localparam int ADDR_GAP  = 40;
  localparam int DATA_GAP  = 1200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rd = 1'b0;
  logic [1:0] req_tgt = 2'd0;
  logic       req_a0 = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic       d_oe;
  logic       yma0, ymcs0_n, ymcs1_n, ymrd_n, ymwr_n;
  logic       saaa0, saacs_n, saawr_n;
  logic       busy;

  psg_access_sched dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_tgt(req_tgt), .req_a0(req_a0), .req_data(req_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .d_in(d_in), .d_out(d_out), .d_oe(d_oe),
    .yma0(yma0), .ymcs0_n(ymcs0_n), .ymcs1_n(ymcs1_n), .ymrd_n(ymrd_n), .ymwr_n(ymwr_n),
    .saaa0(saaa0), .saacs_n(saacs_n), .saawr_n(saawr_n), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {bit rd; int tgt; bit a0; logic [7:0] data;} acc_t;
  typedef struct {int chip; int setup; int hold;} ylog_t;
  acc_t  exp_q[$];
  ylog_t ylog[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_push_cyc = 0;
  int saa_hold_cyc = 0;
  bit din_fix = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) if (ymrd_n) d_in = din_fix ? 8'hA5 : 8'($urandom);

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not seen/allowed (cycle %0d)", name, cyc);
  endtask

  // Pin monitor
  int ym_len = 0, ym_chip = 0, ym_start = 0, saa_len = 0, saa_wr_start = -1;
  bit ym_rd, ym_a0, ym_bad, saa_a0, saa_bad, prev_rdv, ym_end;
  logic [7:0] ym_d, ym_din, saa_d;
  int last_wr_hold[2];
  int last_wr_gap[2];
  bit last_wr_vld[2];

  always @(negedge clk) begin
    acc_t e;
    ym_end = 1'b0;
    if (!rst_n) begin
      ym_len = 0; saa_len = 0; prev_rdv = 1'b0;
      last_wr_vld[0] = 1'b0; last_wr_vld[1] = 1'b0;
    end else begin
      if (!ymcs0_n || !ymcs1_n) begin
        if (ym_len == 0) begin
          ym_chip = ymcs0_n ? 1 : 0;
          ym_rd = !ymrd_n; ym_a0 = yma0; ym_d = d_out; ym_bad = 1'b0; ym_start = cyc;
          if (last_wr_vld[ym_chip])
            chk("ym_recovery_gap", int'((cyc - 1) >= last_wr_hold[ym_chip] + last_wr_gap[ym_chip] + 2), 1);
        end
        if ({ymcs1_n, ymcs0_n} != (ym_chip == 1 ? 2'b01 : 2'b10)) ym_bad = 1'b1;
        if (ymrd_n != !ym_rd || ymwr_n != ym_rd || yma0 != ym_a0 || !saacs_n) ym_bad = 1'b1;
        if (d_oe != !ym_rd || (!ym_rd && d_out != ym_d)) ym_bad = 1'b1;
        ym_din = d_in;
        ym_len++;
      end else if (ym_len > 0) begin
        ym_end = 1'b1;
        if (exp_q.size() == 0) fail("ym_unexpected_access");
        else begin
          e = exp_q.pop_front();
          chk("ym_pulse_len", ym_len, YM_PULSE);
          chk("ym_pulse_consistent", int'(ym_bad), 0);
          chk("ym_target", ym_chip, e.tgt);
          chk("ym_rd", int'(ym_rd), int'(e.rd));
          chk("ym_a0", int'(ym_a0), int'(e.a0));
          chk("ym_hold_strobes", int'({ymcs0_n, ymcs1_n, ymrd_n, ymwr_n}), 4'hF);
          chk("ym_hold_rd_valid", int'(rd_valid), int'(e.rd));
          if (e.rd) chk("ym_rd_data", int'(rd_data), int'(ym_din));
          else begin
            chk("ym_wr_data", int'(ym_d), int'(e.data));
            chk("ym_hold_data", int'({d_oe, d_out}), int'({1'b1, e.data}));
            if (e.tgt < 2) begin
              last_wr_hold[e.tgt] = cyc;
              last_wr_gap[e.tgt]  = e.a0 ? DATA_GAP : ADDR_GAP;
              last_wr_vld[e.tgt]  = 1'b1;
            end
          end
        end
        ylog.push_back('{ym_chip, ym_start - 1, cyc});
        ym_len = 0;
      end

      if (!saacs_n) begin
        if (saa_len == 0) begin
          saa_a0 = saaa0; saa_d = d_out; saa_wr_start = -1; saa_bad = 1'b0;
        end
        if (!saawr_n && saa_wr_start < 0) saa_wr_start = saa_len;
        if (saa_wr_start >= 0 && saawr_n) saa_bad = 1'b1;
        if (!d_oe || d_out != saa_d || saaa0 != saa_a0 || !ymcs0_n || !ymcs1_n) saa_bad = 1'b1;
        saa_len++;
      end else if (saa_len > 0) begin
        if (exp_q.size() == 0) fail("saa_unexpected_access");
        else begin
          e = exp_q.pop_front();
          chk("saa_cs_len", saa_len, SAA_SETUP + SAA_PULSE);
          chk("saa_wr_start", saa_wr_start, SAA_SETUP);
          chk("saa_consistent", int'(saa_bad), 0);
          chk("saa_target", e.tgt, 2);
          chk("saa_rd", int'(e.rd), 0);
          chk("saa_a0", int'(saa_a0), int'(e.a0));
          chk("saa_data", int'(saa_d), int'(e.data));
          chk("saa_hold", int'({saawr_n, d_oe, d_out}), int'({2'b11, e.data}));
        end
        saa_hold_cyc = cyc;
        saa_len = 0;
      end

      if (rd_valid && prev_rdv) fail("rd_valid_multi_cycle");
      if (rd_valid && !ym_end) begin
        if (exp_q.size() == 0) fail("saa_rd_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("saa_rd_target", e.tgt, 2);
          chk("saa_rd_is_read", int'(e.rd), 1);
          chk("saa_rd_a0", int'(saaa0), int'(e.a0));
          chk("saa_rd_data", int'(rd_data), 8'hFF);
        end
      end
      prev_rdv = rd_valid;
    end
  end

  task automatic push(input bit rd, input int tgt, input bit a0, input logic [7:0] data);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_rd = rd; req_tgt = 2'(tgt); req_a0 = a0; req_data = data;
    while (!req_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) fail("push_timeout");
    else begin
      last_push_cyc = cyc;
      @(posedge clk);
      if (tgt != 3) exp_q.push_back('{rd, tgt, a0, data});
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (busy || exp_q.size() != 0) fail("drain_timeout");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    ylog.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    do_reset();
    chk("rst_strobes", int'({ymcs0_n, ymcs1_n, ymrd_n, ymwr_n, saacs_n, saawr_n}), 6'h3F);
    chk("rst_a0", int'({yma0, saaa0}), 0);
    chk("rst_bus", int'({d_oe, d_out}), 0);
    chk("rst_rd", int'({rd_valid, rd_data}), 0);
    chk("rst_busy_ready", int'({busy, req_ready}), 2'b01);

    // YM0 address write
    push(1'b0, 0, 1'b0, 8'h07);
    wait_idle();
    chk("t2_log_count", ylog.size(), 1);
    if (ylog.size() == 1) chk("t2_setup_cycle", ylog[0].setup, last_push_cyc + 2);

    // Recovery pacing: addr, data, addr on YM0
    do_reset();
    push(1'b0, 0, 1'b0, 8'h21);
    push(1'b0, 0, 1'b1, 8'h42);
    push(1'b0, 0, 1'b0, 8'h63);
    wait_idle();
    chk("t3_log_count", ylog.size(), 3);
    if (ylog.size() == 3) begin
      chk("t3_addr_gap", ylog[1].setup - ylog[0].hold, ADDR_GAP + 2);
      chk("t3_data_gap", ylog[2].setup - ylog[1].hold, DATA_GAP + 2);
    end

    // SAA write queued behind a stalled YM0 head
    do_reset();
    push(1'b0, 0, 1'b1, 8'h55);
    push(1'b0, 0, 1'b0, 8'h66);
    push(1'b0, 2, 1'b1, 8'h1C);
    wait_idle();
    chk("t4_log_count", ylog.size(), 2);
    if (ylog.size() == 2) chk("t4_saa_after_ym", int'(saa_hold_cyc > ylog[1].hold), 1);

    // YM1 read, then YM1 write with no recovery in between
    do_reset();
    din_fix = 1'b1;
    push(1'b1, 1, 1'b0, 8'h00);
    push(1'b0, 1, 1'b0, 8'h33);
    wait_idle();
    din_fix = 1'b0;
    chk("t5_rd_data", int'(rd_data), 8'hA5);
    chk("t5_log_count", ylog.size(), 2);
    if (ylog.size() == 2) chk("t5_no_rd_recovery", ylog[1].setup - ylog[0].hold, 2);

    // Fill the FIFO while YM0 recovers
    do_reset();
    push(1'b0, 0, 1'b1, 8'h90);
    wait_idle();
    for (int i = 0; i < 4; i++) push(1'b0, 0, 1'b0, 8'(8'hA0 + i));
    @(negedge clk);
    chk("t6_ready_low_full", int'(req_ready), 0);
    req_valid = 1'b1; req_rd = 1'b0; req_tgt = 2'd0; req_a0 = 1'b0; req_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_ready_stays_low", int'(req_ready), 0);
    end
    req_valid = 1'b0;
    push(1'b0, 0, 1'b0, 8'hA4);
    push(1'b0, 0, 1'b0, 8'hA5);
    wait_idle();
    chk("t6_ready_after_drain", int'(req_ready), 1);

    // Randomized mix including reserved target
    for (int i = 0; i < 40; i++) begin
      int t;
      bit r, a;
      t = $urandom_range(0, 3);
      r = 1'($urandom_range(0, 1));
      a = (t < 2 && !r) ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
      push(r, t, a, 8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();

    // Reset asserted mid-pulse
    do_reset();
    push(1'b0, 0, 1'b0, 8'h11);
    push(1'b0, 2, 1'b0, 8'h22);
    push(1'b0, 1, 1'b1, 8'h33);
    n = 0;
    while (ymwr_n && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ymwr_n) fail("t8_ymwr_never_low");
    #2 rst_n = 1'b0;
    #1;
    chk("t8_async_ymwr", int'(ymwr_n), 1);
    chk("t8_async_cs", int'({ymcs0_n, ymcs1_n}), 2'b11);
    chk("t8_async_doe", int'(d_oe), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("t8_queue_lost", int'({busy, req_ready}), 2'b01);
    chk("t8_idle_strobes", int'({ymcs0_n, ymcs1_n, ymrd_n, ymwr_n, saacs_n, saawr_n}), 6'h3F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
